// File: rtl/sc_scaled_add_ctrl_if.sv
// Host and mux-datapath signal bundle for sc_scaled_add_ctrl.
// The master modport is the host/mux side; the slave modport is the sequencer.
interface sc_scaled_add_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a_val;
  logic [WIDTH-1:0] b_val;
  logic             mux_control;
  logic             mux_a;
  logic             mux_b;
  logic             mux_q;
  logic             stream_valid;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;

  modport master (
    output start, a_val, b_val, mux_q,
    input  mux_control, mux_a, mux_b,
    input  stream_valid, busy, done, result
  );

  modport slave (
    input  start, a_val, b_val, mux_q,
    output mux_control, mux_a, mux_b,
    output stream_valid, busy, done, result
  );
endinterface

// File: rtl/sc_scaled_add_ctrl.sv
// Stochastic scaled-add sequencer: LFSR SNG streams into an external
// 2:1 mux, counts mux ones over one LFSR period, returns ~(a+b)/2.
module sc_scaled_add_ctrl #(
  parameter int WIDTH = 8,
  parameter int SEED  = 1
) (
  input logic                clk,
  input logic                rst_n,
  sc_scaled_add_ctrl_if.slave bus
);
  localparam int N = (1 << WIDTH) - 1;

  // Maximal-length tap masks, one per supported width
  localparam logic [7:0] TAPS =
    (WIDTH == 4) ? 8'h0C :
    (WIDTH == 5) ? 8'h14 :
    (WIDTH == 6) ? 8'h30 :
    (WIDTH == 7) ? 8'h60 : 8'hB8;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_lfsr;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_sel;
  logic [WIDTH-1:0] r_cyc;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_result;

  logic             w_run;
  logic             w_fb;
  logic             w_last;
  logic [WIDTH-1:0] w_rev;
  logic [WIDTH-1:0] w_acc_nxt;

  assign w_run  = (r_state == S_RUN);
  assign w_fb   = ^(r_lfsr & TAPS[WIDTH-1:0]);
  assign w_last = (r_cyc == WIDTH'(N - 1));
  assign w_acc_nxt = r_acc + WIDTH'(bus.mux_q);

  always_comb begin
    w_rev = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_rev[i] = r_lfsr[WIDTH-1-i];
    end
  end

  assign bus.mux_a        = w_run & (r_lfsr <= r_a);
  assign bus.mux_b        = w_run & (w_rev <= r_b);
  assign bus.mux_control  = w_run & r_sel;
  assign bus.stream_valid = w_run;
  assign bus.busy         = w_run;
  assign bus.done         = (r_state == S_DONE);
  assign bus.result       = r_result;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_lfsr   <= WIDTH'(SEED);
      r_a      <= '0;
      r_b      <= '0;
      r_sel    <= 1'b0;
      r_cyc    <= '0;
      r_acc    <= '0;
      r_result <= '0;
    end else begin
      unique case (r_state)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            r_state <= S_RUN;
            r_a     <= bus.a_val;
            r_b     <= bus.b_val;
            r_lfsr  <= WIDTH'(SEED);
            r_sel   <= 1'b1;
            r_cyc   <= '0;
            r_acc   <= '0;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_RUN: begin
          r_acc  <= w_acc_nxt;
          r_lfsr <= {r_lfsr[WIDTH-2:0], w_fb};
          r_sel  <= ~r_sel;
          r_cyc  <= r_cyc + 1'b1;
          if (w_last) begin
            r_result <= w_acc_nxt;
            r_state  <= S_DONE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule
